// File: rtl/mtr_cmd_shaper.sv
// Signed drive command -> slew-limited 10-bit duty plus direction for the PWM stage.
// Duty/direction move only at PWM period boundaries; reversals pass through a zero-duty dead interval.
`timescale 1ns/1ps
module mtr_cmd_shaper #(
  parameter int STEP         = 8,
  parameter int DEAD_PERIODS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] cmd,
  input  logic        cmd_vld,
  output logic [9:0]  duty,
  output logic        dir_fwd,
  output logic        period_tick,
  output logic        at_target,
  output logic        dbg_state
);

  localparam int DW = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS + 1) : 1;
  localparam logic [11:0] STEP_W = 12'(STEP);

  typedef enum logic {RUN = 1'b0, DEAD = 1'b1} state_t;

  // Handshake: cmd_vld is a one-cycle strobe with no back-pressure; every strobe
  // overwrites the target, and the latest target is what the next tick acts on.
  logic [9:0]    cnt;
  logic [10:0]   target;
  logic [11:0]   cur;
  state_t        state;
  logic [DW-1:0] dead_cnt;

  logic [10:0]   cmd_sat;
  logic [11:0]   tgt12, diff, cur_mag, diff_mag, mv;
  logic          tgt_pos, tgt_neg, target_opp;
  state_t        state_next;
  logic [11:0]   cur_next;
  logic [DW-1:0] dead_next;
  logic          dir_next;
  logic [9:0]    duty_next;

  assign period_tick = (cnt == 10'h3FF);
  assign dbg_state   = (state == DEAD);

  // -1024 has no positive counterpart inside 10 bits of duty.
  assign cmd_sat    = (cmd == 11'h400) ? 11'h401 : cmd;
  assign tgt12      = {target[10], target};
  assign diff       = tgt12 - cur;
  assign cur_mag    = cur[11] ? (~cur + 12'd1) : cur;
  assign diff_mag   = diff[11] ? (~diff + 12'd1) : diff;
  assign tgt_neg    = target[10];
  assign tgt_pos    = !target[10] && (target != '0);
  assign target_opp = (tgt_pos && !dir_fwd) || (tgt_neg && dir_fwd);

  always_comb begin
    state_next = state;
    cur_next   = cur;
    dead_next  = dead_cnt;
    dir_next   = dir_fwd;
    mv         = '0;
    if (state == RUN) begin
      if ((cur != '0) && ((target == '0) || (tgt_neg != cur[11]))) begin
        // Wind down toward zero first; never overshoot past it.
        mv       = (STEP_W < cur_mag) ? STEP_W : cur_mag;
        cur_next = cur[11] ? (cur + mv) : (cur - mv);
      end else if ((cur == '0) && target_opp) begin
        state_next = DEAD;
        dead_next  = DW'(DEAD_PERIODS);
      end else begin
        mv       = (STEP_W < diff_mag) ? STEP_W : diff_mag;
        cur_next = diff[11] ? (cur - mv) : (cur + mv);
      end
    end else begin
      cur_next = '0;
      if (dead_cnt > DW'(1)) begin
        dead_next = dead_cnt - DW'(1);
      end else begin
        state_next = RUN;
        dir_next   = dir_fwd ^ target_opp;
      end
    end
    duty_next = cur_next[11] ? (~cur_next[9:0] + 10'd1) : cur_next[9:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      target    <= '0;
      cur       <= '0;
      state     <= RUN;
      dead_cnt  <= '0;
      duty      <= '0;
      dir_fwd   <= 1'b1;
      at_target <= 1'b1;
    end else begin
      cnt <= cnt + 10'd1;
      if (cmd_vld) target <= cmd_sat;
      // A strobe on the tick edge still sees the old target here.
      if (period_tick) begin
        cur       <= cur_next;
        state     <= state_next;
        dead_cnt  <= dead_next;
        dir_fwd   <= dir_next;
        duty      <= duty_next;
        at_target <= (cur_next == tgt12) && (state_next == RUN);
      end
    end
  end

endmodule

// File: tb/tb_mtr_cmd_shaper.sv
// Bench for mtr_cmd_shaper: two instances (STEP=8/DEAD=4 and STEP=600/DEAD=2) share stimulus
// and are compared every cycle against an integer model, plus directed literal checks.
`timescale 1ns/1ps
module tb_mtr_cmd_shaper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] cmd = '0;
  logic        cmd_vld = 1'b0;
  logic [9:0]  duty [2];
  logic        dir_fwd [2];
  logic        period_tick [2];
  logic        at_target [2];
  logic        dbg_state [2];

  int n_checks = 0;
  int n_fail = 0;
  bit cmp_en = 1'b1;

  always #5 clk = ~clk;

  mtr_cmd_shaper #(.STEP(8), .DEAD_PERIODS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_vld(cmd_vld),
    .duty(duty[0]), .dir_fwd(dir_fwd[0]), .period_tick(period_tick[0]),
    .at_target(at_target[0]), .dbg_state(dbg_state[0])
  );

  mtr_cmd_shaper #(.STEP(600), .DEAD_PERIODS(2)) u_big (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_vld(cmd_vld),
    .duty(duty[1]), .dir_fwd(dir_fwd[1]), .period_tick(period_tick[1]),
    .at_target(at_target[1]), .dbg_state(dbg_state[1])
  );

  // Integer model of the drive value per instance.
  int m_step [2] = '{8, 600};
  int m_deadp [2] = '{4, 2};
  int m_cnt;
  int m_tgt [2];
  int m_cur [2];
  int m_dcnt [2];
  int m_duty [2];
  bit m_dead [2];
  bit m_dir [2];
  bit m_at [2];

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_tick(int i);
    int t, c, mv;
    bit opp;
    t = m_tgt[i];
    c = m_cur[i];
    opp = (t > 0 && !m_dir[i]) || (t < 0 && m_dir[i]);
    if (!m_dead[i]) begin
      if (c != 0 && (t == 0 || ((t > 0) != (c > 0)))) begin
        mv = imin(m_step[i], iabs(c));
        c = (c > 0) ? c - mv : c + mv;
      end else if (c == 0 && opp) begin
        m_dead[i] = 1'b1;
        m_dcnt[i] = m_deadp[i];
      end else begin
        mv = imin(m_step[i], iabs(t - c));
        c = (t > c) ? c + mv : c - mv;
      end
    end else if (m_dcnt[i] > 1) begin
      m_dcnt[i] = m_dcnt[i] - 1;
    end else begin
      m_dead[i] = 1'b0;
      if (opp) m_dir[i] = !m_dir[i];
    end
    m_cur[i] = c;
    m_duty[i] = iabs(c);
    m_at[i] = (c == t) && !m_dead[i];
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
      for (int i = 0; i < 2; i++) begin
        m_tgt[i] = 0; m_cur[i] = 0; m_dcnt[i] = 0; m_duty[i] = 0;
        m_dead[i] = 1'b0; m_dir[i] = 1'b1; m_at[i] = 1'b1;
      end
    end else begin
      if (m_cnt == 1023) for (int i = 0; i < 2; i++) model_tick(i);
      if (cmd_vld) begin
        for (int i = 0; i < 2; i++)
          m_tgt[i] = ($signed(cmd) == -1024) ? -1023 : int'($signed(cmd));
      end
      m_cnt = (m_cnt + 1) % 1024;
    end
  end

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Packed as {duty, dir_fwd, at_target, period_tick, dead_state}.
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("inst%0d_outs", i),
              int'({duty[i], dir_fwd[i], at_target[i], period_tick[i], dbg_state[i]}),
              (m_duty[i] << 4) | (int'(m_dir[i]) << 3) | (int'(m_at[i]) << 2) |
              (int'(m_cnt == 1023) << 1) | int'(m_dead[i]));
      end
    end
  end

  task automatic ticks(int n);
    repeat (n) begin
      while (m_cnt != 1023) @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic send(int v);
    cmd = 11'(v);
    cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    check("rst_duty", int'(duty[0]), 0);
    check("rst_dir", int'(dir_fwd[0]), 1);
    check("rst_at", int'(at_target[0]), 1);
    ticks(3);
    check("idle_duty", int'(duty[0]), 0);
    check("idle_at", int'(at_target[0]), 1);

    // Full-scale reverse from rest: dead interval first, then ramp.
    send(-1024);
    ticks(1);
    check("neg_enter_dead", int'(dbg_state[0]), 1);
    check("big_enter_dead", int'(dbg_state[1]), 1);
    ticks(4);
    check("neg_dir_after_dead", int'(dir_fwd[0]), 0);
    check("neg_duty_after_dead", int'(duty[0]), 0);
    check("big_duty_clamped", int'(duty[1]), 1023);
    check("big_dir", int'(dir_fwd[1]), 0);
    check("big_at", int'(at_target[1]), 1);
    ticks(2);
    check("neg_ramp_duty", int'(duty[0]), 16);

    // Forward ramp to +100.
    do_reset();
    send(100);
    for (int k = 1; k <= 13; k++) begin
      ticks(1);
      check($sformatf("fwd_duty_t%0d", k), int'(duty[0]), imin(8 * k, 100));
      check($sformatf("fwd_at_t%0d", k), int'(at_target[0]), (k == 13) ? 1 : 0);
    end

    // Reverse +100 -> -20.
    send(-20);
    for (int k = 1; k <= 21; k++) begin
      int e;
      ticks(1);
      if (k <= 13) e = (100 - 8 * k > 0) ? 100 - 8 * k : 0;
      else if (k <= 18) e = 0;
      else e = imin(8 * (k - 18), 20);
      check($sformatf("rev_duty_t%0d", k), int'(duty[0]), e);
      check($sformatf("rev_dir_t%0d", k), int'(dir_fwd[0]), (k < 18) ? 1 : 0);
    end
    check("rev_at", int'(at_target[0]), 1);

    // +50 then back to 0: no dead interval.
    do_reset();
    send(50);
    ticks(7);
    check("p50_duty", int'(duty[0]), 50);
    send(0);
    for (int k = 1; k <= 7; k++) begin
      ticks(1);
      check($sformatf("zero_duty_t%0d", k), int'(duty[0]), (50 - 8 * k > 0) ? 50 - 8 * k : 0);
      check($sformatf("zero_nodead_t%0d", k), int'(dbg_state[0]), 0);
    end
    check("zero_dir", int'(dir_fwd[0]), 1);
    check("zero_at", int'(at_target[0]), 1);

    // Asynchronous reset mid-ramp.
    send(100);
    ticks(5);
    check("pre_rst_duty", int'(duty[0]), 40);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_duty", int'(duty[0]), 0);
    check("async_dir", int'(dir_fwd[0]), 1);
    check("async_big_duty", int'(duty[1]), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!period_tick[0] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("restart_tick_cycles", n, 1023);

    // Strobe on the tick cycle takes effect one tick later.
    send(60);
    check("tickvld_old_target", int'(duty[0]), 0);
    check("tickvld_big_old", int'(duty[1]), 0);
    ticks(1);
    check("tickvld_new_target", int'(duty[0]), 8);
    check("tickvld_big_new", int'(duty[1]), 60);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
